// File: rtl/alu_cmd_sequencer.sv
// Initiator for a combinational ALU: accepts one command, holds the operands SETTLE cycles, then returns the result.
// Response is valid SETTLE+1 cycles after acceptance; cmd_ready stays low until the response has been accepted.
module alu_cmd_sequencer #(
  parameter int N      = 4,
  parameter int SETTLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [N-1:0] cmd_a,
  input  logic [N-1:0] cmd_b,
  input  logic [1:0]   cmd_op,
  input  logic         cmd_chain,
  output logic [N-1:0] alu_opnd1,
  output logic [N-1:0] alu_opnd2,
  output logic [1:0]   alu_operation,
  input  logic [N-1:0] alu_out,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_result,
  output logic         rsp_zero,
  output logic         rsp_neg,
  output logic [1:0]   rsp_op,
  output logic [7:0]   op_count
);

  localparam int CW = $clog2(SETTLE + 1);

  typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   opnd1_q, opnd1_d;
  logic [N-1:0]   opnd2_q, opnd2_d;
  logic [1:0]     oper_q, oper_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [N-1:0]   rsp_result_q, rsp_result_d;
  logic           rsp_zero_q, rsp_zero_d;
  logic           rsp_neg_q, rsp_neg_d;
  logic [1:0]     rsp_op_q, rsp_op_d;
  logic [N-1:0]   last_result_q, last_result_d;
  logic           last_valid_q, last_valid_d;
  logic [7:0]     op_count_q, op_count_d;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    opnd1_d       = opnd1_q;
    opnd2_d       = opnd2_q;
    oper_d        = oper_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_result_d  = rsp_result_q;
    rsp_zero_d    = rsp_zero_q;
    rsp_neg_d     = rsp_neg_q;
    rsp_op_d      = rsp_op_q;
    last_result_d = last_result_q;
    last_valid_d  = last_valid_q;
    op_count_d    = op_count_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          // Chaining before any result has been captured falls back to cmd_a.
          opnd1_d = (cmd_chain && last_valid_q) ? last_result_q : cmd_a;
          opnd2_d = cmd_b;
          oper_d  = cmd_op;
          cnt_d   = CW'(SETTLE);
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt_q == CW'(1)) begin
          rsp_result_d  = alu_out;
          rsp_zero_d    = (alu_out == '0);
          rsp_neg_d     = alu_out[N-1];
          rsp_op_d      = oper_q;
          last_result_d = alu_out;
          last_valid_d  = 1'b1;
          rsp_valid_d   = 1'b1;
          state_d       = RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          op_count_d  = op_count_q + 8'd1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      opnd1_q       <= '0;
      opnd2_q       <= '0;
      oper_q        <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_result_q  <= '0;
      rsp_zero_q    <= 1'b0;
      rsp_neg_q     <= 1'b0;
      rsp_op_q      <= '0;
      last_result_q <= '0;
      last_valid_q  <= 1'b0;
      op_count_q    <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      opnd1_q       <= opnd1_d;
      opnd2_q       <= opnd2_d;
      oper_q        <= oper_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_result_q  <= rsp_result_d;
      rsp_zero_q    <= rsp_zero_d;
      rsp_neg_q     <= rsp_neg_d;
      rsp_op_q      <= rsp_op_d;
      last_result_q <= last_result_d;
      last_valid_q  <= last_valid_d;
      op_count_q    <= op_count_d;
    end
  end

  assign cmd_ready     = (state_q == IDLE) && !rst;
  assign alu_opnd1     = opnd1_q;
  assign alu_opnd2     = opnd2_q;
  assign alu_operation = oper_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_result    = rsp_result_q;
  assign rsp_zero      = rsp_zero_q;
  assign rsp_neg       = rsp_neg_q;
  assign rsp_op        = rsp_op_q;
  assign op_count      = op_count_q;

endmodule
